// File: rtl/boa_irq_pkg.sv
// boa_irq_pkg: shared definitions for the Boa interrupt controller.
//   register word indices, CLAIM result layout, and the CLAIM priority encoder.
package boa_irq_pkg;

   localparam int IRQ_N = 16;

   localparam logic [2:0] IRQ_REG_ENABLE  = 3'd0;
   localparam logic [2:0] IRQ_REG_MODE    = 3'd1;
   localparam logic [2:0] IRQ_REG_PENDING = 3'd2;
   localparam logic [2:0] IRQ_REG_ACTIVE  = 3'd3;
   localparam logic [2:0] IRQ_REG_SET     = 3'd4;
   localparam logic [2:0] IRQ_REG_CLAIM   = 3'd5;

   typedef struct packed {
      logic       valid;
      logic [3:0] idx;
   } irq_claim_t;

   // lowest-numbered set bit wins; scanning downward lets the last hit stand
   function automatic irq_claim_t irq_prio_enc(input logic [IRQ_N-1:0] active);
      irq_claim_t c;
      c = '0;
      for (int i = IRQ_N - 1; i >= 0; i--) begin
         if (active[i]) begin
            c.valid = 1'b1;
            c.idx   = 4'(i);
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/boa_sync.sv
// boa_sync: multi-flop synchroniser, cleared by rst_n.
//   clk    in          sampling clock
//   rst_n  in          asynchronous active-low clear
//   d      in  [width] asynchronous input
//   q      out [width] synchronised output, stages cycles later
module boa_sync #(
   parameter int stages = 2,
   parameter int width  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] d,
   output logic [width-1:0] q
);

   logic [stages-1:0][width-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[stages-2:0], d};
      end
   end

   assign q = ff[stages-1];

endmodule

// File: rtl/boa_irq_ctl.sv
// boa_irq_ctl: 16-source interrupt controller feeding the CPU irq[15:0] input.
//   clk    in       CPU clock
//   rst_n  in       asynchronous active-low reset
//   src    in  16   raw asynchronous interrupt sources
//   irq    out 16   registered pending & enable
//   re     in       register read strobe
//   we     in       register write strobe (wins over re)
//   addr   in  3    word register index
//   wdata  in  32   write data
//   rdata  out 32   read data, valid while ready
//   ready  out      one-cycle pulse after each accepted access
module boa_irq_ctl
   import boa_irq_pkg::*;
#(
   parameter int sync_stages = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] src,
   output logic [15:0] irq,
   input  logic        re,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready
);

   logic [15:0] src_sync;
   logic [15:0] src_hist;
   logic [15:0] enable;
   logic [15:0] mode;
   logic [15:0] pending;
   logic [15:0] pending_nxt;
   logic [15:0] active;
   logic [15:0] hw_set;
   logic [15:0] sw_set;
   logic [15:0] sw_clr;
   logic [15:0] claim_clr;
   logic [31:0] rd_val;
   logic        rd_acc;
   irq_claim_t  claim;
   logic        unused_wdata_hi;

   assign unused_wdata_hi = ^wdata[31:16];

   boa_sync #(
      .stages (sync_stages),
      .width  (16)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (src),
      .q     (src_sync)
   );

   assign rd_acc = re & ~we;
   assign active = pending & enable;
   assign claim  = irq_prio_enc(active);

   always_comb begin
      hw_set    = src_sync & ~src_hist;
      sw_set    = (we && addr == IRQ_REG_SET)     ? wdata[15:0] : '0;
      sw_clr    = (we && addr == IRQ_REG_PENDING) ? wdata[15:0] : '0;
      claim_clr = '0;
      if (rd_acc && addr == IRQ_REG_CLAIM && claim.valid) begin
         claim_clr[claim.idx] = 1'b1;
      end
      // edge bits: set beats clear; level bits: mirror the synchronised source
      pending_nxt = (mode & (hw_set | sw_set | (pending & ~(sw_clr | claim_clr))))
                  | (~mode & src_sync);
   end

   always_comb begin
      rd_val = '0;
      case (addr)
         IRQ_REG_ENABLE:  rd_val = {16'b0, enable};
         IRQ_REG_MODE:    rd_val = {16'b0, mode};
         IRQ_REG_PENDING: rd_val = {16'b0, pending};
         IRQ_REG_ACTIVE:  rd_val = {16'b0, active};
         IRQ_REG_CLAIM:   rd_val = {27'b0, claim};
         default:         rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable   <= '0;
         mode     <= '0;
         pending  <= '0;
         src_hist <= '0;
         irq      <= '0;
         rdata    <= '0;
         ready    <= 1'b0;
      end else begin
         // history tracks in every mode so a level->edge switch sees no false edge
         src_hist <= src_sync;
         pending  <= pending_nxt;
         irq      <= active;
         ready    <= re | we;
         rdata    <= rd_acc ? rd_val : '0;
         if (we) begin
            case (addr)
               IRQ_REG_ENABLE: enable <= wdata[15:0];
               IRQ_REG_MODE:   mode   <= wdata[15:0];
               default:        ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boa_irq_ctl.sv
// tb_boa_irq_ctl: scoreboard bench for boa_irq_ctl (sync_stages = 2).
module tb_boa_irq_ctl;
   import boa_irq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] src = '0;
   logic [15:0] irq;
   logic        re = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ready;

   int n_chk  = 0;
   int n_fail = 0;

   string       q_tag[$];
   logic [31:0] q_exp[$];
   bit          q_cmp[$];

   boa_irq_ctl #(.sync_stages(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .src   (src),
      .irq   (irq),
      .re    (re),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .ready (ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && ready) begin
         if (q_exp.size() == 0) begin
            chk("ready_unexpected", 32'(ready), 32'd0);
         end else begin
            string       t;
            logic [31:0] e;
            bit          c;
            t = q_tag.pop_front();
            e = q_exp.pop_front();
            c = q_cmp.pop_front();
            if (c) chk(t, rdata, e);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      q_tag.push_back("wr"); q_exp.push_back('0); q_cmp.push_back(1'b0);
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
      re = 1'b1; addr = a;
      q_tag.push_back(tag); q_exp.push_back(exp); q_cmp.push_back(1'b1);
      @(posedge clk); #1;
      re = 1'b0;
   endtask

   task automatic rw_both(input logic [2:0] a, input logic [31:0] d);
      re = 1'b1; we = 1'b1; addr = a; wdata = d;
      q_tag.push_back("rw_both_rdata"); q_exp.push_back('0); q_cmp.push_back(1'b1);
      @(posedge clk); #1;
      re = 1'b0; we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      for (int i = 0; i < 8; i++) rd(3'(i), 32'd0, $sformatf("rst_reg%0d", i));

      // edge latch on src[0]
      wr(IRQ_REG_MODE, 32'h0001);
      wr(IRQ_REG_ENABLE, 32'h0001);
      cyc(2);
      src[0] = 1'b1;
      cyc(1);
      src[0] = 1'b0;
      cyc(2);
      chk("edge_pre", 32'(irq[0]), 32'd0);
      cyc(1);
      chk("edge_irq", 32'(irq[0]), 32'd1);
      cyc(5);
      chk("edge_hold", 32'(irq[0]), 32'd1);
      rd(IRQ_REG_PENDING, 32'h0001, "edge_pend");
      wr(IRQ_REG_PENDING, 32'h0001);
      chk("edge_clr_lag", 32'(irq[0]), 32'd1);
      cyc(1);
      chk("edge_clr", 32'(irq[0]), 32'd0);
      rd(IRQ_REG_PENDING, 32'h0, "edge_pend_clr");

      // level follow on src[15]
      wr(IRQ_REG_MODE, 32'h0);
      wr(IRQ_REG_ENABLE, 32'h8000);
      cyc(3);
      src[15] = 1'b1;
      for (int k = 0; k < 16; k++) begin
         cyc(1);
         if (k == 9) src[15] = 1'b0;
         chk($sformatf("level_k%0d", k), 32'(irq[15]), 32'((k >= 3 && k <= 12) ? 1 : 0));
      end
      src[15] = 1'b1;
      cyc(5);
      wr(IRQ_REG_PENDING, 32'h8000);
      rd(IRQ_REG_PENDING, 32'h8000, "level_noclr");
      chk("level_irq_hold", 32'(irq[15]), 32'd1);
      src[15] = 1'b0;
      cyc(6);
      chk("level_drop", 32'(irq[15]), 32'd0);

      // claim priority between edge sources 3 and 9
      wr(IRQ_REG_ENABLE, 32'h0);
      wr(IRQ_REG_MODE, 32'h0208);
      wr(IRQ_REG_ENABLE, 32'h0208);
      src[3] = 1'b1; src[9] = 1'b1;
      cyc(1);
      src = '0;
      cyc(4);
      rd(IRQ_REG_ACTIVE, 32'h0208, "claim_active");
      rd(IRQ_REG_CLAIM, 32'h13, "claim_first");
      rd(IRQ_REG_CLAIM, 32'h19, "claim_second");
      rd(IRQ_REG_CLAIM, 32'h00, "claim_empty");
      rd(IRQ_REG_PENDING, 32'h0, "claim_pend_end");

      // set-wins races on bit 5
      wr(IRQ_REG_ENABLE, 32'h0020);
      wr(IRQ_REG_MODE, 32'h0020);
      wr(IRQ_REG_SET, 32'h0020);
      rd(IRQ_REG_PENDING, 32'h0020, "race_preset");
      src[5] = 1'b1;
      cyc(1);
      src[5] = 1'b0;
      cyc(1);
      wr(IRQ_REG_PENDING, 32'h0020);
      rd(IRQ_REG_PENDING, 32'h0020, "race_wr_clr");
      wr(IRQ_REG_PENDING, 32'h0020);
      rd(IRQ_REG_PENDING, 32'h0, "race_plain_clr");
      wr(IRQ_REG_SET, 32'h0020);
      src[5] = 1'b1;
      cyc(1);
      src[5] = 1'b0;
      cyc(1);
      rd(IRQ_REG_CLAIM, 32'h15, "race_claim");
      rd(IRQ_REG_PENDING, 32'h0020, "race_claim_pend");
      wr(IRQ_REG_PENDING, 32'h0020);
      rd(IRQ_REG_PENDING, 32'h0, "race_cleanup");

      // software trigger and mask
      wr(IRQ_REG_ENABLE, 32'h0);
      wr(IRQ_REG_MODE, 32'h0042);
      wr(IRQ_REG_ENABLE, 32'h0002);
      wr(IRQ_REG_SET, 32'h0042);
      rd(IRQ_REG_ACTIVE, 32'h0002, "sw_active");
      chk("sw_irq", 32'(irq), 32'h0002);
      rd(IRQ_REG_PENDING, 32'h0042, "sw_pend");
      rd(IRQ_REG_SET, 32'h0, "sw_set_rd");
      wr(IRQ_REG_CLAIM, 32'hFFFF_FFFF);
      wr(IRQ_REG_ENABLE, 32'h0042);
      chk("mask_lag", 32'(irq), 32'h0002);
      cyc(1);
      chk("mask_irq", 32'(irq), 32'h0042);
      rw_both(IRQ_REG_MODE, 32'h0042);
      rd(IRQ_REG_PENDING, 32'h0042, "sw_pend_after");
      rd(IRQ_REG_ENABLE, 32'h0042, "sw_enable_rd");
      cyc(2);

      // reset while a read is in flight
      re = 1'b1; addr = IRQ_REG_ENABLE;
      @(posedge clk); #1;
      chk("midrst_ready_pre", 32'(ready), 32'd1);
      chk("midrst_irq_pre", 32'(irq), 32'h0042);
      rst_n = 1'b0;
      re = 1'b0;
      #1;
      chk("midrst_irq", 32'(irq), 32'd0);
      chk("midrst_ready", 32'(ready), 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      for (int i = 0; i < 8; i++) rd(3'(i), 32'd0, $sformatf("post_rst_reg%0d", i));
      cyc(3);
      chk("sb_empty", 32'(q_exp.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
